layer_5_ctrl: RTL and testbench

Frame sequencer for the 2x2/stride-2 max-pool layer that follows it. It gates an upstream pixel stream into the pool's valid_in and tracks the raster position of each accepted beat. It counts pooled outputs and flushes the pool's line buffers between frames. It reports completion, busy and error status to the network-level scheduler.

---
 rtl/layer_5_ctrl.sv | 123 ++++++++++++
 tb/tb_layer_5_ctrl.sv | 287 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/layer_5_ctrl.sv
// Frame sequencer for the 2x2/stride-2 max-pool layer: gates the pixel
// stream into the pool, tracks raster position, counts pooled outputs,
// flushes the pool between frames and reports status to the scheduler.
module layer_5_ctrl #(
  parameter int IMG_SIZE      = 104,
  parameter int CNT_W         = 14,
  parameter int DRAIN_TIMEOUT = 256
) (
  input  logic             Clk,
  input  logic             Rst,
  input  logic             start,
  input  logic             src_valid,
  output logic             src_ready,
  output logic             pool_rst,
  output logic             pool_valid_in,
  input  logic             pool_valid_out,
  output logic [CNT_W-1:0] in_row,
  output logic [CNT_W-1:0] in_col,
  output logic [CNT_W-1:0] out_count,
  output logic             busy,
  output logic             done,
  output logic             error
);

  localparam int TMR_W = $clog2(DRAIN_TIMEOUT) + 1;
  localparam logic [CNT_W-1:0] LAST_IDX  = CNT_W'(IMG_SIZE - 1);
  localparam logic [CNT_W-1:0] OUT_TOTAL = CNT_W'((IMG_SIZE / 2) * (IMG_SIZE / 2));
  localparam logic [TMR_W-1:0] TMR_LAST  = TMR_W'(DRAIN_TIMEOUT - 1);

  typedef enum logic [2:0] {IDLE, CLEAR, RUN, DRAIN, DONE} state_t;

  state_t           state, state_next;
  logic [TMR_W-1:0] drain_timer;
  logic             accept;
  logic             drain_timeout;

  // State register
  always_ff @(posedge Clk) begin
    if (Rst) state <= IDLE;
    else     state <= state_next;
  end

  // Next-state decode and the combinational handshake outputs
  always_comb begin
    state_next    = state;
    src_ready     = 1'b0;
    pool_valid_in = 1'b0;
    pool_rst      = Rst;
    accept        = 1'b0;
    drain_timeout = 1'b0;
    case (state)
      IDLE: begin
        if (start) state_next = CLEAR;
      end
      CLEAR: begin
        pool_rst   = 1'b1;
        state_next = RUN;
      end
      RUN: begin
        src_ready     = !Rst;
        pool_valid_in = src_valid && !Rst;
        accept        = src_valid && !Rst;
        if (accept && in_row == LAST_IDX && in_col == LAST_IDX) state_next = DRAIN;
      end
      DRAIN: begin
        // completion wins over timeout when both hold in the same cycle
        if (out_count == OUT_TOTAL) begin
          state_next = DONE;
        end else if (drain_timer == TMR_LAST) begin
          state_next    = DONE;
          drain_timeout = 1'b1;
        end
      end
      DONE: begin
        state_next = IDLE;
      end
      default: state_next = IDLE;
    endcase
  end

  // Counters, drain timer and registered status flags
  always_ff @(posedge Clk) begin
    if (Rst) begin
      in_row      <= '0;
      in_col      <= '0;
      out_count   <= '0;
      drain_timer <= '0;
      busy        <= 1'b0;
      done        <= 1'b0;
      error       <= 1'b0;
    end else begin
      busy <= (state_next != IDLE);
      done <= (state_next == DONE);
      if (state == IDLE && start) begin
        in_row      <= '0;
        in_col      <= '0;
        out_count   <= '0;
        drain_timer <= '0;
        error       <= 1'b0;
      end else begin
        if (accept) begin
          if (in_col == LAST_IDX) begin
            in_col <= '0;
            in_row <= in_row + 1'b1;
          end else begin
            in_col <= in_col + 1'b1;
          end
        end
        if (state == DRAIN) drain_timer <= drain_timer + 1'b1;
        if (pool_valid_out) begin
          if (state == RUN || state == DRAIN) begin
            if (out_count == OUT_TOTAL) error <= 1'b1;
            else                        out_count <= out_count + 1'b1;
          end else begin
            error <= 1'b1;
          end
        end
        if (drain_timeout) error <= 1'b1;
      end
    end
  end

endmodule

// File: tb/tb_layer_5_ctrl.sv
// Directed bench for layer_5_ctrl with IMG_SIZE=4 and a small behavioural
// max-pool model that answers each odd-row/odd-column beat one cycle later.
module tb_layer_5_ctrl;

  localparam int IMG  = 4;
  localparam int CW   = 6;
  localparam int DTO  = 16;

  logic          Clk, Rst, start, src_valid;
  logic          src_ready, pool_rst, pool_valid_in, pool_valid_out;
  logic [CW-1:0] in_row, in_col, out_count;
  logic          busy, done, error;

  int  n_checks = 0;
  int  n_fail   = 0;

  // pool model controls
  logic pm_reset;
  int   pm_limit;
  logic extra_pv;
  int   pm_beats;
  int   pm_outs;
  logic pm_pend;

  layer_5_ctrl #(.IMG_SIZE(IMG), .CNT_W(CW), .DRAIN_TIMEOUT(DTO)) dut (
    .Clk(Clk), .Rst(Rst), .start(start), .src_valid(src_valid),
    .src_ready(src_ready), .pool_rst(pool_rst), .pool_valid_in(pool_valid_in),
    .pool_valid_out(pool_valid_out), .in_row(in_row), .in_col(in_col),
    .out_count(out_count), .busy(busy), .done(done), .error(error)
  );

  initial Clk = 1'b0;
  always #5 Clk = ~Clk;

  // Pool model: one output per 2x2 window, emitted after its last pixel
  always @(posedge Clk) begin
    if (pm_reset) begin
      pm_beats <= 0;
      pm_outs  <= 0;
      pm_pend  <= 1'b0;
    end else begin
      pm_pend <= 1'b0;
      if (pool_valid_in) begin
        pm_beats <= pm_beats + 1;
        if (((pm_beats / IMG) % 2 == 1) && ((pm_beats % IMG) % 2 == 1) && pm_outs < pm_limit) begin
          pm_pend <= 1'b1;
          pm_outs <= pm_outs + 1;
        end
      end
    end
  end

  assign pool_valid_out = pm_pend | extra_pv;

  task automatic tick;
    @(posedge Clk);
    #1;
  endtask

  task automatic pool_model_clear;
    pm_reset = 1'b1;
    tick();
    pm_reset = 1'b0;
  endtask

  task automatic wait_done(input int limit, output int n, output bit seen);
    n    = 0;
    seen = 1'b0;
    while (!seen && n < limit) begin
      if (done) seen = 1'b1;
      else begin
        tick();
        n++;
      end
    end
  endtask

  task automatic test_reset;
    Rst = 1'b1; src_valid = 1'b1; start = 1'b0;
    tick(); tick();
    n_checks++; if (in_row !== 0)    begin n_fail++; $display("FAIL reset_in_row: got %0d expected 0", in_row); end
    n_checks++; if (in_col !== 0)    begin n_fail++; $display("FAIL reset_in_col: got %0d expected 0", in_col); end
    n_checks++; if (out_count !== 0) begin n_fail++; $display("FAIL reset_out_count: got %0d expected 0", out_count); end
    n_checks++; if (busy !== 1'b0)   begin n_fail++; $display("FAIL reset_busy: got %b expected 0", busy); end
    n_checks++; if (done !== 1'b0)   begin n_fail++; $display("FAIL reset_done: got %b expected 0", done); end
    n_checks++; if (error !== 1'b0)  begin n_fail++; $display("FAIL reset_error: got %b expected 0", error); end
    n_checks++; if (pool_rst !== 1'b1) begin n_fail++; $display("FAIL reset_pool_rst: got %b expected 1", pool_rst); end
    n_checks++; if (src_ready !== 1'b0) begin n_fail++; $display("FAIL reset_src_ready: got %b expected 0", src_ready); end
    n_checks++; if (pool_valid_in !== 1'b0) begin n_fail++; $display("FAIL reset_pool_valid_in: got %b expected 0", pool_valid_in); end
    Rst = 1'b0; src_valid = 1'b0;
    #1;
    n_checks++; if (pool_rst !== 1'b0) begin n_fail++; $display("FAIL idle_pool_rst: got %b expected 0", pool_rst); end
  endtask

  task automatic test_nominal;
    pm_limit = 4;
    pool_model_clear();
    start = 1'b1; src_valid = 1'b1;
    tick();                    // now CLEAR
    start = 1'b0;
    #1;
    n_checks++; if (pool_rst !== 1'b1) begin n_fail++; $display("FAIL nom_clear_pool_rst: got %b expected 1", pool_rst); end
    n_checks++; if (busy !== 1'b1)     begin n_fail++; $display("FAIL nom_clear_busy: got %b expected 1", busy); end
    n_checks++; if (pool_valid_in !== 1'b0) begin n_fail++; $display("FAIL nom_clear_pvi: got %b expected 0", pool_valid_in); end
    tick();                    // now RUN
    n_checks++; if (pool_rst !== 1'b0) begin n_fail++; $display("FAIL nom_run_pool_rst: got %b expected 0", pool_rst); end
    for (int i = 0; i < IMG * IMG; i++) begin
      n_checks++; if (pool_valid_in !== 1'b1) begin n_fail++; $display("FAIL nom_pvi_beat%0d: got %b expected 1", i, pool_valid_in); end
      n_checks++; if (in_col !== i % IMG) begin n_fail++; $display("FAIL nom_col_beat%0d: got %0d expected %0d", i, in_col, i % IMG); end
      n_checks++; if (in_row !== i / IMG) begin n_fail++; $display("FAIL nom_row_beat%0d: got %0d expected %0d", i, in_row, i / IMG); end
      tick();
    end
    // first DRAIN cycle: last pooled output still in flight
    n_checks++; if (in_row !== IMG) begin n_fail++; $display("FAIL nom_drain_row: got %0d expected %0d", in_row, IMG); end
    n_checks++; if (in_col !== 0)   begin n_fail++; $display("FAIL nom_drain_col: got %0d expected 0", in_col); end
    n_checks++; if (src_ready !== 1'b0) begin n_fail++; $display("FAIL nom_drain_ready: got %b expected 0", src_ready); end
    n_checks++; if (pool_valid_in !== 1'b0) begin n_fail++; $display("FAIL nom_drain_pvi: got %b expected 0", pool_valid_in); end
    n_checks++; if (out_count !== 3) begin n_fail++; $display("FAIL nom_drain_cnt0: got %0d expected 3", out_count); end
    tick();
    n_checks++; if (out_count !== 4) begin n_fail++; $display("FAIL nom_drain_cnt1: got %0d expected 4", out_count); end
    n_checks++; if (done !== 1'b0)   begin n_fail++; $display("FAIL nom_early_done: got %b expected 0", done); end
    tick();
    n_checks++; if (done !== 1'b1)   begin n_fail++; $display("FAIL nom_done: got %b expected 1", done); end
    n_checks++; if (error !== 1'b0)  begin n_fail++; $display("FAIL nom_error: got %b expected 0", error); end
    tick();
    n_checks++; if (done !== 1'b0)   begin n_fail++; $display("FAIL nom_done_pulse: got %b expected 0", done); end
    n_checks++; if (busy !== 1'b0)   begin n_fail++; $display("FAIL nom_busy_after: got %b expected 0", busy); end
  endtask

  task automatic test_bubble;
    int  acc;
    int  n;
    bit  seen;
    logic sv;
    pm_limit = 4;
    pool_model_clear();
    start = 1'b1; src_valid = 1'b0;
    tick();
    start = 1'b0;
    tick();                    // RUN
    acc = 0;
    for (int c = 0; c < 8; c++) begin
      sv = (c % 2 == 0);
      src_valid = sv;
      #1;
      n_checks++; if (pool_valid_in !== sv) begin n_fail++; $display("FAIL bub_pvi_c%0d: got %b expected %b", c, pool_valid_in, sv); end
      n_checks++; if (in_col !== acc % IMG) begin n_fail++; $display("FAIL bub_col_c%0d: got %0d expected %0d", c, in_col, acc % IMG); end
      n_checks++; if (in_row !== acc / IMG) begin n_fail++; $display("FAIL bub_row_c%0d: got %0d expected %0d", c, in_row, acc / IMG); end
      tick();
      if (sv) acc++;
    end
    n_checks++; if (in_col !== 0) begin n_fail++; $display("FAIL bub_wrap_col: got %0d expected 0", in_col); end
    n_checks++; if (in_row !== 1) begin n_fail++; $display("FAIL bub_wrap_row: got %0d expected 1", in_row); end
    src_valid = 1'b1;
    wait_done(60, n, seen);
    n_checks++; if (seen !== 1'b1) begin n_fail++; $display("FAIL bub_done_timeout: got %b expected 1", seen); end
    n_checks++; if (out_count !== 4) begin n_fail++; $display("FAIL bub_out_count: got %0d expected 4", out_count); end
    n_checks++; if (error !== 1'b0)  begin n_fail++; $display("FAIL bub_error: got %b expected 0", error); end
    tick();
  endtask

  task automatic test_missing;
    int n;
    bit seen;
    pm_limit = 3;
    pool_model_clear();
    start = 1'b1; src_valid = 1'b1;
    tick();
    start = 1'b0;
    tick();
    for (int i = 0; i < IMG * IMG; i++) tick();
    // first DRAIN cycle
    n_checks++; if (out_count !== 3) begin n_fail++; $display("FAIL miss_cnt: got %0d expected 3", out_count); end
    wait_done(40, n, seen);
    n_checks++; if (seen !== 1'b1) begin n_fail++; $display("FAIL miss_done_seen: got %b expected 1", seen); end
    n_checks++; if (n !== DTO) begin n_fail++; $display("FAIL miss_drain_len: got %0d expected %0d", n, DTO); end
    n_checks++; if (error !== 1'b1) begin n_fail++; $display("FAIL miss_error: got %b expected 1", error); end
    tick();
    tick(); tick();
    n_checks++; if (error !== 1'b1) begin n_fail++; $display("FAIL miss_error_sticky: got %b expected 1", error); end
    n_checks++; if (busy !== 1'b0)  begin n_fail++; $display("FAIL miss_busy: got %b expected 0", busy); end
  endtask

  task automatic test_extra;
    pm_limit = 4;
    pool_model_clear();
    n_checks++; if (error !== 1'b1) begin n_fail++; $display("FAIL ext_pre_error: got %b expected 1", error); end
    start = 1'b1; src_valid = 1'b1;
    tick();
    start = 1'b0;
    n_checks++; if (error !== 1'b0) begin n_fail++; $display("FAIL ext_start_clears: got %b expected 0", error); end
    tick();
    for (int i = 0; i < IMG * IMG; i++) tick();
    tick();                    // DRAIN with out_count=4
    n_checks++; if (out_count !== 4) begin n_fail++; $display("FAIL ext_cnt_pre: got %0d expected 4", out_count); end
    extra_pv = 1'b1;
    tick();
    extra_pv = 1'b0;
    n_checks++; if (done !== 1'b1)   begin n_fail++; $display("FAIL ext_done: got %b expected 1", done); end
    n_checks++; if (error !== 1'b1)  begin n_fail++; $display("FAIL ext_error: got %b expected 1", error); end
    n_checks++; if (out_count !== 4) begin n_fail++; $display("FAIL ext_saturate: got %0d expected 4", out_count); end
    tick();
  endtask

  task automatic test_start_during_run;
    int n;
    bit seen;
    pm_limit = 4;
    pool_model_clear();
    start = 1'b1; src_valid = 1'b1;
    tick();
    start = 1'b0;
    tick();
    for (int i = 0; i < 5; i++) tick();
    start = 1'b1; src_valid = 1'b0;
    tick();
    start = 1'b0;
    n_checks++; if (in_col !== 1) begin n_fail++; $display("FAIL sdr_col: got %0d expected 1", in_col); end
    n_checks++; if (in_row !== 1) begin n_fail++; $display("FAIL sdr_row: got %0d expected 1", in_row); end
    n_checks++; if (src_ready !== 1'b1) begin n_fail++; $display("FAIL sdr_still_run: got %b expected 1", src_ready); end
    n_checks++; if (pool_rst !== 1'b0)  begin n_fail++; $display("FAIL sdr_pool_rst: got %b expected 0", pool_rst); end
    src_valid = 1'b1;
    wait_done(60, n, seen);
    n_checks++; if (seen !== 1'b1) begin n_fail++; $display("FAIL sdr_done_seen: got %b expected 1", seen); end
    n_checks++; if (error !== 1'b0) begin n_fail++; $display("FAIL sdr_error: got %b expected 0", error); end
    tick();                    // IDLE
    extra_pv = 1'b1;
    tick();
    extra_pv = 1'b0;
    n_checks++; if (error !== 1'b1)  begin n_fail++; $display("FAIL stray_idle_error: got %b expected 1", error); end
    n_checks++; if (out_count !== 4) begin n_fail++; $display("FAIL stray_idle_count: got %0d expected 4", out_count); end
  endtask

  task automatic test_reset_mid;
    int n_in;
    bit seen;
    pm_limit = 4;
    pool_model_clear();
    start = 1'b1; src_valid = 1'b1;
    tick();
    start = 1'b0;
    tick();
    for (int i = 0; i < 7; i++) tick();
    n_checks++; if (in_col !== 3) begin n_fail++; $display("FAIL rm_pre_col: got %0d expected 3", in_col); end
    Rst = 1'b1;
    tick();
    n_checks++; if (in_row !== 0 || in_col !== 0 || out_count !== 0) begin n_fail++; $display("FAIL rm_counters: got %0d/%0d/%0d expected 0/0/0", in_row, in_col, out_count); end
    n_checks++; if (busy !== 1'b0)      begin n_fail++; $display("FAIL rm_busy: got %b expected 0", busy); end
    n_checks++; if (src_ready !== 1'b0) begin n_fail++; $display("FAIL rm_ready: got %b expected 0", src_ready); end
    n_checks++; if (error !== 1'b0)     begin n_fail++; $display("FAIL rm_error: got %b expected 0", error); end
    Rst = 1'b0;
    tick();
    n_checks++; if (done !== 1'b0) begin n_fail++; $display("FAIL rm_no_done: got %b expected 0", done); end
    n_checks++; if (src_ready !== 1'b0) begin n_fail++; $display("FAIL rm_idle_ready: got %b expected 0", src_ready); end
    pool_model_clear();
    start = 1'b1;
    tick();
    start = 1'b0;
    n_in = 0;
    seen = 1'b0;
    for (int c = 0; c < 60 && !seen; c++) begin
      if (pool_valid_in) n_in++;
      if (done) seen = 1'b1;
      else tick();
    end
    n_checks++; if (seen !== 1'b1) begin n_fail++; $display("FAIL rm2_done_seen: got %b expected 1", seen); end
    n_checks++; if (n_in !== 16)   begin n_fail++; $display("FAIL rm2_beats: got %0d expected 16", n_in); end
    n_checks++; if (out_count !== 4) begin n_fail++; $display("FAIL rm2_out_count: got %0d expected 4", out_count); end
    n_checks++; if (error !== 1'b0)  begin n_fail++; $display("FAIL rm2_error: got %b expected 0", error); end
    tick();
  endtask

  initial begin
    Rst = 1'b1; start = 1'b0; src_valid = 1'b0;
    pm_reset = 1'b1; pm_limit = 4; extra_pv = 1'b0;
    test_reset();
    test_nominal();
    test_bubble();
    test_missing();
    test_extra();
    test_start_during_run();
    test_reset_mid();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
